// File: rtl/vga_ring_gen.sv
// rtl/vga_ring_gen.sv - VGA timing generator with a 3-stage pipelined ring/border renderer
module vga_ring_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int PIX_DIV  = 2,
    parameter int R_INIT   = 100,
    parameter int R_MIN    = 20,
    parameter int R_MAX    = 200,
    parameter int BAND     = 100,
    parameter int CW       = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [1:0]    i_sel,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic [11:0]   o_x,
    output logic [11:0]   o_y,
    output logic          o_frame,
    output logic [CW-1:0] o_red,
    output logic [CW-1:0] o_grn,
    output logic [CW-1:0] o_blu
);
    localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_ON  = H_ACTIVE + H_FP;
    localparam int HS_OFF = HS_ON + H_SYNC;
    localparam int VS_ON  = V_ACTIVE + V_FP;
    localparam int VS_OFF = VS_ON + V_SYNC;
    localparam int DW     = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic HS_ACT = (HS_POL != 0);
    localparam logic VS_ACT = (VS_POL != 0);

    typedef enum logic {GROW, SHRINK} state_t;

    logic [DW-1:0] div_q, div_d;
    logic          pix_en;
    logic [11:0]   hc_q, hc_d, vc_q, vc_d;
    logic          armed_q;
    logic          sof;
    state_t        state_q, state_d;
    logic [11:0]   r_q, r_d;
    logic [23:0]   rr_q;
    logic [1:0]    mode_q, mode_d;

    logic               de_raw, hs_raw, vs_raw;
    logic signed [12:0] dx_q, dy_q;
    logic               s1_de_q, s1_hs_q, s1_vs_q, s1_fr_q;
    logic [11:0]        s1_x_q, s1_y_q;

    logic signed [25:0] dx_w, dy_w;
    logic [24:0]        d2_d, d2_q;
    logic               s2_de_q, s2_hs_q, s2_vs_q, s2_fr_q;
    logic [11:0]        s2_x_q, s2_y_q;

    logic signed [26:0] diff;
    logic [26:0]        diff_abs;
    logic               ring_hit, border, pix_d;
    logic               hs_q, vs_q, de_q, fr_q, pix_q;
    logic [11:0]        x_q, y_q;

    assign pix_en = (div_q == '0);

    always_comb begin
        div_d = (div_q == DW'(PIX_DIV - 1)) ? '0 : div_q + 1'b1;
        hc_d  = hc_q;
        vc_d  = vc_q;
        if (pix_en) begin
            if (hc_q == 12'(H_TOT - 1)) begin
                hc_d = '0;
                vc_d = (vc_q == 12'(V_TOT - 1)) ? '0 : vc_q + 12'd1;
            end else begin
                hc_d = hc_q + 12'd1;
            end
        end
    end

    // The counters already sit at (0,0) out of reset; that first pass is not a frame start,
    // so the first real frame start is the first wrap back to (0,0).
    assign sof = pix_en && armed_q && (hc_q == '0) && (vc_q == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_q   <= '0;
            hc_q    <= '0;
            vc_q    <= '0;
            armed_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            armed_q <= armed_q | pix_en;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= GROW;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (sof) begin
            if (i_sel != 2'b10) begin
                state_d = GROW;
            end else if (state_q == GROW) begin
                if (r_q + 12'd1 >= 12'(R_MAX)) state_d = SHRINK;
            end else begin
                if (r_q - 12'd1 <= 12'(R_MIN)) state_d = GROW;
            end
        end
    end

    always_comb begin
        r_d    = r_q;
        mode_d = mode_q;
        if (sof) begin
            mode_d = i_sel;
            if (i_sel != 2'b10)     r_d = 12'(R_INIT);
            else if (state_q == GROW) r_d = r_q + 12'd1;
            else                    r_d = r_q - 12'd1;
        end
    end

    // r*r is registered together with r, so it is stable for the whole frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q    <= 12'(R_INIT);
            rr_q   <= 24'(R_INIT * R_INIT);
            mode_q <= 2'b00;
        end else begin
            r_q    <= r_d;
            rr_q   <= 24'(r_d) * 24'(r_d);
            mode_q <= mode_d;
        end
    end

    assign de_raw = (hc_q < 12'(H_ACTIVE)) && (vc_q < 12'(V_ACTIVE));
    assign hs_raw = (hc_q >= 12'(HS_ON)) && (hc_q < 12'(HS_OFF));
    assign vs_raw = (vc_q >= 12'(VS_ON)) && (vc_q < 12'(VS_OFF));

    assign dx_w = 26'(dx_q);
    assign dy_w = 26'(dy_q);
    assign d2_d = 25'(dx_w * dx_w + dy_w * dy_w);

    always_comb begin
        diff     = $signed({2'b00, d2_q}) - $signed({3'b000, rr_q});
        diff_abs = diff[26] ? 27'(-diff) : 27'(diff);
        ring_hit = (mode_q != 2'b00) && (diff_abs < 27'(BAND));
        border   = (mode_q == 2'b11) &&
                   ((s2_x_q == '0) || (s2_x_q == 12'(H_ACTIVE - 1)) ||
                    (s2_y_q == '0) || (s2_y_q == 12'(V_ACTIVE - 1)));
        pix_d    = s2_de_q && (ring_hit || border);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dx_q    <= '0;
            dy_q    <= '0;
            s1_de_q <= 1'b0;
            s1_hs_q <= 1'b0;
            s1_vs_q <= 1'b0;
            s1_fr_q <= 1'b0;
            s1_x_q  <= '0;
            s1_y_q  <= '0;
            d2_q    <= '0;
            s2_de_q <= 1'b0;
            s2_hs_q <= 1'b0;
            s2_vs_q <= 1'b0;
            s2_fr_q <= 1'b0;
            s2_x_q  <= '0;
            s2_y_q  <= '0;
            hs_q    <= ~HS_ACT;
            vs_q    <= ~VS_ACT;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            pix_q   <= 1'b0;
        end else if (pix_en) begin
            dx_q    <= $signed(13'(hc_q)) - 13'sd1 * 13'(H_ACTIVE / 2);
            dy_q    <= $signed(13'(vc_q)) - 13'sd1 * 13'(V_ACTIVE / 2);
            s1_de_q <= de_raw;
            s1_hs_q <= hs_raw;
            s1_vs_q <= vs_raw;
            s1_fr_q <= sof;
            s1_x_q  <= de_raw ? hc_q : '0;
            s1_y_q  <= de_raw ? vc_q : '0;
            d2_q    <= d2_d;
            s2_de_q <= s1_de_q;
            s2_hs_q <= s1_hs_q;
            s2_vs_q <= s1_vs_q;
            s2_fr_q <= s1_fr_q;
            s2_x_q  <= s1_x_q;
            s2_y_q  <= s1_y_q;
            hs_q    <= s2_hs_q ? HS_ACT : ~HS_ACT;
            vs_q    <= s2_vs_q ? VS_ACT : ~VS_ACT;
            de_q    <= s2_de_q;
            x_q     <= s2_x_q;
            y_q     <= s2_y_q;
            pix_q   <= pix_d;
        end
    end

    // Frame strobe lasts one clock even when a pixel spans several clocks.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) fr_q <= 1'b0;
        else          fr_q <= pix_en && s2_fr_q;
    end

    assign o_hsync = hs_q;
    assign o_vsync = vs_q;
    assign o_de    = de_q;
    assign o_x     = x_q;
    assign o_y     = y_q;
    assign o_frame = fr_q;
    assign o_red   = {CW{pix_q}};
    assign o_grn   = {CW{pix_q}};
    assign o_blu   = {CW{pix_q}};
endmodule

// File: tb/tb_vga_ring_gen.sv
// tb/tb_vga_ring_gen.sv - scoreboard bench for vga_ring_gen on scaled-down timings
module tb_vga_ring_gen;
    localparam int HA = 32, HFP = 2, HSY = 4, HBP = 2;
    localparam int VA = 24, VFP = 1, VSY = 2, VBP = 2;
    localparam int DIV = 2;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME_CLK = HT * VT * DIV;
    localparam int FIRST_FRAME_CLK = FRAME_CLK + 3 * DIV;
    localparam int W = 7;

    typedef struct {
        int f;
        int x;
        int y;
        int rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic [1:0]  sel, sel2;
    logic        hs, vs, de, frame;
    logic [11:0] x, y;
    logic [0:0]  red, grn, blu;
    logic        hs2, vs2, de2, frame2;
    logic [11:0] x2, y2;
    logic [0:0]  red2, grn2, blu2;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   fc = 0;
    bit   tim_done = 0;
    bit   tim2_done = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    vga_ring_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(0), .VS_POL(0), .PIX_DIV(DIV),
        .R_INIT(10), .R_MIN(8), .R_MAX(11), .BAND(10), .CW(1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sel(sel),
        .o_hsync(hs), .o_vsync(vs), .o_de(de), .o_x(x), .o_y(y), .o_frame(frame),
        .o_red(red), .o_grn(grn), .o_blu(blu)
    );

    vga_ring_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .PIX_DIV(1),
        .R_INIT(2), .R_MIN(1), .R_MAX(3), .BAND(2), .CW(1)
    ) dut2 (
        .i_clk(clk), .i_rst_n(rst2_n), .i_sel(sel2),
        .o_hsync(hs2), .o_vsync(vs2), .o_de(de2), .o_x(x2), .o_y(y2), .o_frame(frame2),
        .o_red(red2), .o_grn(grn2), .o_blu(blu2)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int f, input int px, input int py, input int rgb);
        exp_t e;
        e.f = f; e.x = px; e.y = py; e.rgb = rgb;
        q.push_back(e);
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    // Monitor: frame counter plus in-order match of scoreboard entries against the pixel stream.
    always @(negedge clk) begin
        if (!rst_n) begin
            fc = 0;
        end else begin
            if (frame) begin
                fc++;
                check("frame_at_origin", int'(x) + int'(y) + 1 - int'(de), 0);
            end
            if (!de) begin
                if ({red, grn, blu} != 3'b000) check("blank_black", int'({red, grn, blu}), 0);
            end else if (q.size() > 0 && q[0].f == fc && q[0].x == int'(x) && q[0].y == int'(y)) begin
                check($sformatf("pix_f%0d_x%0d_y%0d", q[0].f, q[0].x, q[0].y),
                      int'({red, grn, blu}), q[0].rgb);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #600000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
        $finish;
    end

    // Timing of the VGA-like instance, measured on negedge samples.
    initial begin
        int n;
        wait (fc == 1);
        wait (hs); wait (!hs);
        @(negedge clk);
        n = 0;
        while (!hs) begin n++; @(negedge clk); end
        check("hsync_low_clocks", n, HSY * DIV);
        while (hs) begin n++; @(negedge clk); end
        check("line_period_clocks", n, HT * DIV);
        wait (de);
        @(negedge clk);
        n = 0;
        while (de) begin n++; @(negedge clk); end
        check("de_high_clocks", n, HA * DIV);
        wait (vs); wait (!vs);
        @(negedge clk);
        n = 0;
        while (!vs) begin n++; @(negedge clk); end
        check("vsync_low_clocks", n, VSY * HT * DIV);
        wait (frame);
        @(negedge clk);
        n = 0;
        do begin @(negedge clk); n++; end while (!frame);
        check("frame_period_clocks", n, FRAME_CLK);
        @(negedge clk);
        check("frame_pulse_one_clock", int'(frame), 0);
        wait (frame);
        @(negedge clk);
        begin
            bit prev = 0;
            n = 0;
            do begin
                if (de && !prev) n++;
                prev = de;
                @(negedge clk);
            end while (!frame);
        end
        check("de_lines_per_frame", n, VA);
        tim_done = 1;
    end

    // Small active-high instance at one clock per pixel.
    initial begin
        int n, mx, my, nde;
        wait (rst2_n);
        wait (frame2);
        @(negedge clk);
        check("t2_frame_x", int'(x2), 0);
        check("t2_frame_y", int'(y2), 0);
        n = 0; mx = 0; my = 0; nde = 0;
        do begin
            if (de2) begin
                nde++;
                if (int'(x2) > mx) mx = int'(x2);
                if (int'(y2) > my) my = int'(y2);
            end
            @(negedge clk);
            n++;
        end while (!frame2);
        check("t2_frame_period", n, 84);
        check("t2_max_x", mx, 7);
        check("t2_max_y", my, 3);
        check("t2_de_pixels", nde, 32);
        wait (!hs2); wait (hs2);
        @(negedge clk);
        n = 0;
        while (hs2) begin n++; @(negedge clk); end
        check("t2_hsync_high_clocks", n, 2);
        wait (!vs2); wait (vs2);
        @(negedge clk);
        n = 0;
        while (vs2) begin n++; @(negedge clk); end
        check("t2_vsync_high_clocks", n, 12);
        tim2_done = 1;
    end

    initial begin
        int n, d;
        rst_n = 1'b0; rst2_n = 1'b0;
        sel = 2'b01; sel2 = 2'b01;
        repeat (3) @(negedge clk);
        check("rst_hsync", int'(hs), 1);
        check("rst_vsync", int'(vs), 1);
        check("rst_de", int'(de), 0);
        check("rst_xy", int'(x) + int'(y), 0);
        check("rst_frame", int'(frame), 0);
        check("rst_rgb", int'({red, grn, blu}), 0);
        check("rst2_syncs_idle_low", int'(hs2) + int'(vs2), 0);

        // Frame 0 still renders with the reset mode (black); frame 1 is static ring r=10.
        push(0, 26, 12, 0);
        push(1, 0, 0, 0);   push(1, 16, 12, 0); push(1, 26, 12, W);
        push(1, 27, 12, 0); push(1, 16, 22, W);
        rst_n = 1'b1; rst2_n = 1'b1;

        wait (fc == 1); wait (y == 12'd5);
        sel = 2'b11;
        push(2, 0, 0, W);   push(2, 31, 0, W);  push(2, 1, 1, 0);
        push(2, 16, 12, 0); push(2, 26, 12, W); push(2, 31, 23, W);

        wait (fc == 2); wait (y == 12'd5);
        sel = 2'b10;
        push(3, 26, 12, 0); push(3, 27, 12, W); push(3, 28, 12, 0);
        push(4, 26, 12, W); push(4, 27, 12, 0);
        push(5, 25, 12, W); push(5, 26, 12, 0);
        push(6, 23, 12, 0); push(6, 24, 12, W); push(6, 25, 12, 0);

        // Switch to static mid-frame: r=8 holds for the rest of frame 6.
        wait (fc == 6); wait (y == 12'd2);
        sel = 2'b01;
        push(7, 25, 12, 0); push(7, 26, 12, W);

        wait (fc == 7); wait (y == 12'd20);
        check("scoreboard_drained", q.size(), 0);
        wait (tim_done && tim2_done);

        wait (de && y == 12'd10 && x == 12'd20);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_hsync", int'(hs), 1);
        check("midrst_vsync", int'(vs), 1);
        check("midrst_de", int'(de), 0);
        check("midrst_rgb", int'({red, grn, blu}), 0);
        sel = 2'b11;
        @(negedge clk);
        push(0, 0, 0, 0);
        push(1, 0, 0, W);
        rst_n = 1'b1;
        n = 0;
        while (n < 5000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (frame) break;
        end
        d = (n > FIRST_FRAME_CLK) ? n - FIRST_FRAME_CLK : FIRST_FRAME_CLK - n;
        check("first_frame_clocks", (d <= DIV) ? FIRST_FRAME_CLK : n, FIRST_FRAME_CLK);
        wait (y == 12'd3);
        check("scoreboard_drained_after_reset", q.size(), 0);
        summary();
        $finish;
    end
endmodule
